// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage slice for the MIPS-lite core.
// Decodes the ALU control, runs the ALU with zero/overflow/negative flags,
// keeps a clocked status register of those flags, and computes PC+4 and
// the branch target.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aluop1,
  input  logic             aluop0,
  input  logic [5:0]       opcode,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [15:0]      imm16,
  output logic [2:0]       gout,
  output logic [WIDTH-1:0] alu_result,
  output logic             zout,
  output logic             vout,
  output logic             nout,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [5:0] OPC_ORI = 6'b001101;

  localparam logic [2:0] G_AND = 3'b000;
  localparam logic [2:0] G_OR  = 3'b001;
  localparam logic [2:0] G_ADD = 3'b010;
  localparam logic [2:0] G_SUB = 3'b110;
  localparam logic [2:0] G_NOR = 3'b100;
  localparam logic [2:0] G_SLT = 3'b111;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] imm_ext;
  logic             v_add;
  logic             v_sub;
  logic             slt_bit;

  // Shared adder/subtractor and their signed-overflow terms
  assign sum     = a + b;
  assign diff    = a - b;
  assign v_add   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign v_sub   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  // Sign of the difference corrected by overflow gives a true signed compare
  assign slt_bit = diff[MSB] ^ v_sub;

  // ALU control decode; ori overrides ALUOp
  always_comb begin
    gout = G_ADD;
    if (opcode == OPC_ORI) begin
      gout = G_OR;
    end else if (!aluop1 && !aluop0) begin
      gout = G_ADD;
    end else if (!aluop1) begin
      gout = G_SUB;
    end else begin
      case (funct)
        4'b0000: gout = G_ADD;
        4'b0010: gout = G_SUB;
        4'b0100: gout = G_AND;
        4'b0101: gout = G_OR;
        4'b0111: gout = G_NOR;
        4'b1010: gout = G_SLT;
        default: gout = G_ADD;
      endcase
    end
  end

  // ALU operation select and overflow flag
  always_comb begin
    alu_result = '0;
    vout       = 1'b0;
    case (gout)
      G_AND: alu_result = a & b;
      G_OR:  alu_result = a | b;
      G_ADD: begin
        alu_result = sum;
        vout       = v_add;
      end
      G_SUB: begin
        alu_result = diff;
        vout       = v_sub;
      end
      G_NOR: alu_result = ~(a | b);
      G_SLT: alu_result = WIDTH'(slt_bit);
      default: alu_result = '0;
    endcase
  end

  assign zout = (alu_result == '0);
  assign nout = alu_result[MSB];

  // Status register: captures the combinational flags every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
    end else begin
      v_flag <= vout;
      z_flag <= zout;
      n_flag <= nout;
    end
  end

  // PC increment and branch target adders
  assign imm_ext       = {{(WIDTH-16){imm16[15]}}, imm16};
  assign pc_plus4      = pc + WIDTH'(4);
  assign branch_target = pc_plus4 + (imm_ext << 2);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus
// randomized stimulus compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluop1, aluop0;
  logic [5:0]  opcode;
  logic [3:0]  funct;
  logic [31:0] a, b, pc;
  logic [15:0] imm16;
  logic [2:0]  gout;
  logic [31:0] alu_result;
  logic        zout, vout, nout;
  logic        v_flag, z_flag, n_flag;
  logic [31:0] pc_plus4, branch_target;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .aluop1(aluop1), .aluop0(aluop0),
    .opcode(opcode), .funct(funct), .a(a), .b(b), .pc(pc), .imm16(imm16),
    .gout(gout), .alu_result(alu_result), .zout(zout), .vout(vout),
    .nout(nout), .v_flag(v_flag), .z_flag(z_flag), .n_flag(n_flag),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  g;
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        n;
  } res_t;

  // Reference: decode table, then operate on signed integers in 64-bit space
  function automatic res_t model(input logic a1, input logic a0,
                                 input logic [5:0] op, input logic [3:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
    res_t   m;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m  = '0;
    if (op == 6'd13)      m.g = 3'd1;
    else if (!a1 && !a0)  m.g = 3'd2;
    else if (!a1)         m.g = 3'd6;
    else begin
      case (fn)
        4'd0:    m.g = 3'd2;
        4'd2:    m.g = 3'd6;
        4'd4:    m.g = 3'd0;
        4'd5:    m.g = 3'd1;
        4'd7:    m.g = 3'd4;
        4'd10:   m.g = 3'd7;
        default: m.g = 3'd2;
      endcase
    end
    case (m.g)
      3'd0: m.r = x & y;
      3'd1: m.r = x | y;
      3'd2: begin
        s   = sx + sy;
        m.r = 32'(s);
        m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd6: begin
        s   = sx - sy;
        m.r = 32'(s);
        m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: m.r = ~(x | y);
      3'd7: m.r = (sx < sy) ? 32'd1 : 32'd0;
      default: m.r = 32'd0;
    endcase
    m.z = (m.r == 32'd0);
    m.n = m.r[31];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected status flags: what the model said at the last capturing edge
  logic ev, ez, en;
  always @(posedge clk or posedge rst) begin
    res_t mm;
    if (rst) begin
      ev <= 1'b0; ez <= 1'b0; en <= 1'b0;
    end else begin
      mm = model(aluop1, aluop0, opcode, funct, a, b);
      ev <= mm.v; ez <= mm.z; en <= mm.n;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    res_t m;
    if (run_cmp) begin
      m = model(aluop1, aluop0, opcode, funct, a, b);
      chk("gout",          32'(gout),   32'(m.g));
      chk("alu_result",    alu_result,  m.r);
      chk("zout",          32'(zout),   32'(m.z));
      chk("vout",          32'(vout),   32'(m.v));
      chk("nout",          32'(nout),   32'(m.n));
      chk("v_flag",        32'(v_flag), 32'(ev));
      chk("z_flag",        32'(z_flag), 32'(ez));
      chk("n_flag",        32'(n_flag), 32'(en));
      chk("pc_plus4",      pc_plus4,    32'(longint'(pc) + 4));
      chk("branch_target", branch_target,
          32'(longint'(pc) + 4 + longint'($signed(imm16)) * 4));
    end
  end

  // Apply operands just after a rising edge, then settle
  task automatic set_ops(input logic [1:0] op2, input logic [5:0] opc,
                         input logic [3:0] fn, input logic [31:0] x,
                         input logic [31:0] y);
    @(posedge clk);
    #1;
    {aluop1, aluop0} = op2;
    opcode = opc; funct = fn; a = x; b = y;
    #1;
  endtask

  logic [3:0] sweep_fn [7];
  logic [2:0] sweep_g  [7];

  initial begin
    rst = 1'b1;
    aluop1 = 1'b0; aluop0 = 1'b0; opcode = '0; funct = '0;
    a = '0; b = '0; pc = '0; imm16 = '0;
    sweep_fn = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0111, 4'b1010, 4'b1111};
    sweep_g  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b100, 3'b111, 3'b010};

    #2;
    chk("reset v_flag", 32'(v_flag), 32'd0);
    chk("reset z_flag", 32'(z_flag), 32'd0);
    chk("reset n_flag", 32'(n_flag), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_cmp = 1'b1;

    // Decode sweep
    for (int i = 0; i < 7; i++) begin
      set_ops(2'b10, 6'd0, sweep_fn[i], 32'd9, 32'd4);
      chk("decode funct", 32'(gout), 32'(sweep_g[i]));
    end
    set_ops(2'b00, 6'b001101, 4'd0, 32'd9, 32'd4);
    chk("decode ori", 32'(gout), 32'd1);

    // Add overflow and its registered copy one edge later
    set_ops(2'b00, 6'd0, 4'd0, 32'h7FFFFFFF, 32'd1);
    chk("add ovf result", alu_result, 32'h80000000);
    chk("add ovf vout", 32'(vout), 32'd1);
    chk("add ovf nout", 32'(nout), 32'd1);
    chk("add ovf zout", 32'(zout), 32'd0);
    @(posedge clk); #1;
    chk("add ovf v_flag", 32'(v_flag), 32'd1);
    chk("add ovf n_flag", 32'(n_flag), 32'd1);

    // Async reset between edges clears immediately and holds until release
    #2 rst = 1'b1;
    #1;
    chk("async rst v_flag", 32'(v_flag), 32'd0);
    chk("async rst z_flag", 32'(z_flag), 32'd0);
    chk("async rst n_flag", 32'(n_flag), 32'd0);
    @(posedge clk); #2;
    chk("rst held v_flag", 32'(v_flag), 32'd0);
    rst = 1'b0;
    #1;
    chk("released pre-edge v_flag", 32'(v_flag), 32'd0);
    @(posedge clk); #1;
    chk("first capture v_flag", 32'(v_flag), 32'd1);

    // Subtract zero / negative
    set_ops(2'b01, 6'd0, 4'd0, 32'd5, 32'd5);
    chk("sub zero result", alu_result, 32'd0);
    chk("sub zero zout", 32'(zout), 32'd1);
    set_ops(2'b01, 6'd0, 4'd0, 32'd3, 32'd5);
    chk("sub neg result", alu_result, 32'hFFFFFFFE);
    chk("sub neg nout", 32'(nout), 32'd1);
    chk("sub neg vout", 32'(vout), 32'd0);

    // slt across overflow
    set_ops(2'b10, 6'd0, 4'b1010, 32'h80000000, 32'd1);
    chk("slt min<1", alu_result, 32'd1);
    chk("slt vout", 32'(vout), 32'd0);
    set_ops(2'b10, 6'd0, 4'b1010, 32'd1, 32'h80000000);
    chk("slt 1<min", alu_result, 32'd0);

    // Logic ops
    set_ops(2'b10, 6'd0, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and", alu_result, 32'h00F000F0);
    set_ops(2'b10, 6'd0, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("or", alu_result, 32'hFFF0FFF0);
    set_ops(2'b10, 6'd0, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("nor", alu_result, 32'h000F000F);

    // Adders
    @(posedge clk); #1;
    pc = 32'h00000010; imm16 = 16'hFFFE;
    #1;
    chk("pc_plus4", pc_plus4, 32'h00000014);
    chk("branch_target", branch_target, 32'h0000000C);
    pc = 32'hFFFFFFFC;
    #1;
    chk("pc_plus4 wrap", pc_plus4, 32'h00000000);

    // Randomized stimulus with occasional mid-cycle reset pulses
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      {aluop1, aluop0} = 2'($urandom_range(0, 3));
      opcode = ($urandom_range(0, 3) == 0) ? 6'b001101 : 6'($urandom);
      funct  = ($urandom_range(0, 1) == 0) ? 4'($urandom)
             : sweep_fn[$urandom_range(0, 6)];
      case ($urandom_range(0, 4))
        0: a = 32'h7FFFFFFF;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = 32'($urandom_range(0, 2));
        2: b = 32'h80000000;
        default: b = $urandom;
      endcase
      pc    = $urandom;
      imm16 = 16'($urandom);
      rst   = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmp = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
